rr_mux_n: RTL and testbench
===========================

Name: rr_mux_n

Overview:
- Parametrised N-to-1 multiplexer; next generation of the team's 4:1 mux.
- Generalised in channel count and data width.
- Adds a registered output with valid/ready handshake on each input and on the output.
- Two selection modes: round-robin arbitration across valid channels, or fixed select.
- Sits between multiple producer channels and a single downstream consumer; funnels one word per accepted transfer.

Parameters:
- N, 4, number of input channels (1..16).
- W, 8, data width per channel in bits.
- SELW, $clog2(N) (1 when N=1), width of the select/index fields.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel accept; one-hot or zero.
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SELW  channel index used when mode=1.
- out_data  output  W  registered data word.
- out_valid  output  1  out_data holds an undelivered word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_sel  output  SELW  index of the channel that supplied out_data.

Behaviour:
- Reset (async assert, applied immediately): out_valid=0, out_data=0, out_sel=0, last-grant pointer=N-1 (so channel 0 has first priority), in_ready=0. Release is synchronous to clk.
- Output register is a single stage.
- can_load = !out_valid | out_ready.
- Grant computed combinationally each cycle:
  - mode=0: first channel with in_valid=1, searching cyclically from pointer+1 through pointer (wrapping at N-1 -> 0).
  - mode=1: channel sel if sel<N and in_valid[sel]=1; else no grant. sel>=N never grants and never wraps.
- in_ready[g]=1 only for granted channel g and only when can_load=1. All other bits 0. in_ready depends on in_valid (documented combinational path).
- Transfer on channel g (in_valid[g] & in_ready[g]): next edge loads out_data=in_data[g], out_sel=g, out_valid=1; pointer<=g in both modes.
- Output drain (out_valid & out_ready) with no new load: next edge out_valid=0; out_data and out_sel hold their values.
- Simultaneous drain and load: new word replaces old in the same edge; out_valid stays 1. Sustained throughput is 1 word/cycle.
- Stall (out_valid=1, out_ready=0): out_data and out_sel held stable; all in_ready=0; pointer unchanged.
- Latency: input acceptance to out_valid is 1 cycle.
- Fairness: in mode=0 with all N channels continuously valid and out_ready=1, grants rotate 0,1,...,N-1,0 with no channel skipped.
- Mode change takes effect the next cycle for arbitration. A word already in the output register is unaffected.
- N=1: channel 0 always selected; mode and sel ignored; out_sel=0.
- Reset asserted mid-transfer: the held word is discarded (out_valid=0 immediately); no in_ready is asserted while rst=1.

Optional Feature:
- Macro RR_MUX_STATS_EN.
- Defined:
  - Adds output port xfer_count (16 bits): number of completed output drains (out_valid & out_ready).
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst.
  - Increments on the same edge the drain occurs.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: assert rst mid-cycle with out_valid=1 -> out_valid=0, in_ready=0 immediately; after release with in_valid=4'b1111, in_ready=4'b0001 (channel 0 first).
- Round-robin: N=4, W=8, all valid with data 8'hA0..8'hA3, out_ready=1 -> out_data sequence A0,A1,A2,A3,A0; out_sel 0,1,2,3,0; one word per cycle.
- Skip and wrap: in_valid=4'b1010 with pointer at 3 -> grant ch1 (out_sel=1), then ch3, then ch1 again.
- Fixed mode: mode=1, sel=2, in_valid=4'b1111 -> only in_ready[2] ever 1. sel=2 with in_valid[2]=0 -> in_ready=0 and out_valid falls after drain.
- Backpressure: out_ready=0 for 3 cycles with word 8'h5C held -> out_data=8'h5C and out_sel stable, in_ready=0; raise out_ready -> drain plus next load on the same edge.
- With RR_MUX_STATS_EN: 10 drains -> xfer_count=10; preload near 16'hFFFF via 65535+ drains -> holds at 16'hFFFF.

Source files
------------

// File: rtl/rr_mux_n.sv
// N-to-1 round-robin / fixed-select mux with a single registered output stage and valid/ready handshakes.
// Optional transfer counter (xfer_count) enabled by defining RR_MUX_STATS_EN.
module rr_mux_n #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int SELW = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N*W-1:0]    in_data,
   input  logic [N-1:0]      in_valid,
   output logic [N-1:0]      in_ready,
   input  logic              mode,
   input  logic [SELW-1:0]   sel,
   output logic [W-1:0]      out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SELW-1:0]   out_sel
`ifdef RR_MUX_STATS_EN
   ,
   output logic [15:0]       xfer_count
`endif
);

   logic [W-1:0]    out_data_q,  out_data_d;
   logic            out_valid_q, out_valid_d;
   logic [SELW-1:0] out_sel_q,   out_sel_d;
   logic [SELW-1:0] ptr_q,       ptr_d;

   logic            can_load;
   logic            gnt_vld;
   logic [SELW-1:0] gnt_idx;
   logic            xfer;
   logic            drain;

   // Grant search: in round-robin the nearest valid channel after the pointer wins,
   // so scanning from the farthest candidate down lets the last hit be the winner.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      if (N == 1) begin
         gnt_vld = in_valid[0];
      end else if (mode) begin
         for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
               gnt_vld = 1'b1;
               gnt_idx = SELW'(i);
            end
         end
      end else begin
         for (int k = N; k >= 1; k--) begin
            if (in_valid[(int'(ptr_q) + k) % N]) begin
               gnt_vld = 1'b1;
               gnt_idx = SELW'((int'(ptr_q) + k) % N);
            end
         end
      end
   end

   always_comb begin
      can_load = ~out_valid_q | out_ready;
      xfer     = gnt_vld & can_load & ~rst;
      drain    = out_valid_q & out_ready;
      in_ready = '0;
      if (xfer) in_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data[int'(gnt_idx)*W +: W];
         out_sel_d   = gnt_idx;
         ptr_d       = gnt_idx;
      end else if (drain) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= SELW'(N - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_sel   = out_sel_q;

`ifdef RR_MUX_STATS_EN
   logic [15:0] cnt_q, cnt_d;

   // Saturating count of words handed to the consumer.
   always_comb begin
      cnt_d = cnt_q;
      if (drain && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign xfer_count = cnt_q;
`endif

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed, table-driven bench for rr_mux_n (N=4, W=8) with hand sequences for reset and backpressure.
module tb_rr_mux_n;

   localparam int N = 4;
   localparam int W = 8;
   localparam int SELW = 2;

   logic             clk;
   logic             rst;
   logic [N*W-1:0]   in_data;
   logic [N-1:0]     in_valid;
   logic [N-1:0]     in_ready;
   logic             mode;
   logic [SELW-1:0]  sel;
   logic [W-1:0]     out_data;
   logic             out_valid;
   logic             out_ready;
   logic [SELW-1:0]  out_sel;
`ifdef RR_MUX_STATS_EN
   logic [15:0]      xfer_count;
`endif

   int checks = 0;
   int errors = 0;

   rr_mux_n #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sel   (out_sel)
`ifdef RR_MUX_STATS_EN
      ,
      .xfer_count(xfer_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] iv;
      logic       md;
      logic [1:0] sl;
      logic       ordy;
      logic [3:0] exp_rdy;
      logic       exp_ov;
      logic [7:0] exp_od;
      logic [1:0] exp_os;
   } vec_t;

   vec_t vec[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] iv, input logic md, input logic [1:0] sl, input logic ordy,
                      input logic [3:0] rdy, input logic ov, input logic [7:0] od, input logic [1:0] os);
      vec_t v;
      v.iv = iv; v.md = md; v.sl = sl; v.ordy = ordy;
      v.exp_rdy = rdy; v.exp_ov = ov; v.exp_od = od; v.exp_os = os;
      vec.push_back(v);
   endtask

   initial begin
      rst = 1'b1; in_data = 32'hA3A2A1A0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;

      // round-robin over all four channels, one word per cycle
      add(4'b1111, 0, 0, 1, 4'b0001, 1, 8'hA0, 0);
      add(4'b1111, 0, 0, 1, 4'b0010, 1, 8'hA1, 1);
      add(4'b1111, 0, 0, 1, 4'b0100, 1, 8'hA2, 2);
      add(4'b1111, 0, 0, 1, 4'b1000, 1, 8'hA3, 3);
      add(4'b1111, 0, 0, 1, 4'b0001, 1, 8'hA0, 0);
      // move pointer to 3, then skip and wrap on 1010
      add(4'b1000, 0, 0, 1, 4'b1000, 1, 8'hA3, 3);
      add(4'b1010, 0, 0, 1, 4'b0010, 1, 8'hA1, 1);
      add(4'b1010, 0, 0, 1, 4'b1000, 1, 8'hA3, 3);
      add(4'b1010, 0, 0, 1, 4'b0010, 1, 8'hA1, 1);
      // fixed select on channel 2
      add(4'b1111, 1, 2, 1, 4'b0100, 1, 8'hA2, 2);
      add(4'b1111, 1, 2, 1, 4'b0100, 1, 8'hA2, 2);
      add(4'b1011, 1, 2, 1, 4'b0000, 0, 8'hA2, 2);
      // back to round-robin from pointer 2
      add(4'b1111, 0, 0, 1, 4'b1000, 1, 8'hA3, 3);
      add(4'b0000, 0, 0, 1, 4'b0000, 0, 8'hA3, 3);
      // load into empty register while stalled, then hold
      add(4'b1111, 0, 0, 0, 4'b0001, 1, 8'hA0, 0);
      add(4'b1111, 0, 0, 0, 4'b0000, 1, 8'hA0, 0);
      add(4'b1111, 0, 0, 0, 4'b0000, 1, 8'hA0, 0);
      add(4'b1111, 0, 0, 0, 4'b0000, 1, 8'hA0, 0);
      add(4'b1111, 0, 0, 1, 4'b0010, 1, 8'hA1, 1);

      // reset state
      @(negedge clk); @(negedge clk);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_data",  32'(out_data),  32'd0);
      chk("rst out_sel",   32'(out_sel),   32'd0);
      in_valid = 4'b1111;
      #1 chk("rst in_ready held", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1 chk("post-rst in_ready", 32'(in_ready), 32'b0001);
      in_valid = '0;

      for (int i = 0; i < vec.size(); i++) begin
         @(negedge clk);
         in_valid = vec[i].iv; mode = vec[i].md; sel = vec[i].sl; out_ready = vec[i].ordy;
         #1 chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vec[i].exp_rdy));
         @(posedge clk); #1;
         chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vec[i].exp_ov));
         chk($sformatf("v%0d out_data", i),  32'(out_data),  32'(vec[i].exp_od));
         chk($sformatf("v%0d out_sel", i),   32'(out_sel),   32'(vec[i].exp_os));
      end

      // backpressure: drain+load 5C, stall 3 cycles, then drain+load on the same edge
      @(negedge clk);
      mode = 1'b1; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1; in_data = 32'hA35CA1A0;
      #1 chk("bp load in_ready", 32'(in_ready), 32'b0100);
      @(posedge clk); #1;
      chk("bp load data", 32'(out_data), 32'h5C);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         out_ready = 1'b0; in_data = 32'hA377A1A0;
         #1 chk($sformatf("bp stall%0d in_ready", c), 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         chk($sformatf("bp stall%0d data", c),  32'(out_data),  32'h5C);
         chk($sformatf("bp stall%0d sel", c),   32'(out_sel),   32'd2);
         chk($sformatf("bp stall%0d valid", c), 32'(out_valid), 32'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1 chk("bp release in_ready", 32'(in_ready), 32'b0100);
      @(posedge clk); #1;
      chk("bp release data",  32'(out_data),  32'h77);
      chk("bp release valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      in_valid = '0;
      @(posedge clk); #1;
      chk("bp drain valid", 32'(out_valid), 32'd0);
      chk("bp drain data hold", 32'(out_data), 32'h77);

      // reset mid-transfer while a word is held
      @(negedge clk);
      in_data = 32'hA3A2A1A0; mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b0;
      #1 chk("mr load in_ready", 32'(in_ready), 32'b1000);
      @(posedge clk); #1;
      chk("mr held data", 32'(out_data), 32'hA3);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mr out_valid", 32'(out_valid), 32'd0);
      chk("mr out_data",  32'(out_data),  32'd0);
      chk("mr in_ready",  32'(in_ready),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("mr release in_ready", 32'(in_ready), 32'b0001);
      in_valid = '0;

`ifdef RR_MUX_STATS_EN
      chk("cnt reset", 32'(xfer_count), 32'd0);
      @(negedge clk);
      in_valid = 4'b0001; out_ready = 1'b1; mode = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      in_valid = '0;
      @(posedge clk); #1;
      chk("cnt 10 drains", 32'(xfer_count), 32'd10);
      @(negedge clk);
      in_valid = 4'b0001;
      repeat (65600) @(posedge clk);
      #1 chk("cnt saturate", 32'(xfer_count), 32'hFFFF);
      repeat (5) @(posedge clk);
      #1 chk("cnt hold sat", 32'(xfer_count), 32'hFFFF);
      in_valid = '0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
